// File: rtl/stage6_tile_feeder.sv
// stage6_tile_feeder: fetches four operand vectors per tile from a 1-cycle read port, runs
// pipe_stage6 once per tile, then streams the lane-interleaved acc vector out beat by beat.
module stage6_tile_feeder #(
    parameter int WIDTH    = 16,
    parameter int PARALLEL = 3,
    parameter int PARA     = 8,
    parameter int TILE     = 128,
    parameter int ADDR_W   = 16,
    parameter int NT_W     = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [ADDR_W-1:0]              cmd_base,
    input  logic [NT_W-1:0]                cmd_ntiles,
    input  logic [4:0]                     cmd_stage,
    input  logic [8*PARA-1:0]              cmd_bound,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic [PARALLEL*WIDTH-1:0]      rd_data,
    output logic                           s6_start,
    output logic [PARALLEL*WIDTH-1:0]      s6_op1,
    output logic [PARALLEL*WIDTH-1:0]      s6_op2,
    output logic [PARALLEL*WIDTH-1:0]      s6_op3,
    output logic [PARALLEL*WIDTH-1:0]      s6_op4,
    output logic [4:0]                     s6_stage,
    output logic [8*PARA-1:0]              s6_bound,
    input  logic                           s6_finished,
    input  logic [PARALLEL*TILE*WIDTH-1:0] s6_acc,
    input  logic [PARALLEL*WIDTH-1:0]      s6_scal,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [PARALLEL*WIDTH-1:0]      res_data,
    output logic [PARALLEL*WIDTH-1:0]      res_scal,
    output logic                           res_last,
    output logic                           job_done,
    output logic                           job_err,
    output logic [2:0]                     dbg_state
);
    localparam int LW     = PARALLEL * WIDTH;
    localparam int BEAT_W = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [NT_W-1:0]   ntiles_q, tile_q, tile_inc;
    logic [4:0]        stage_q;
    logic [8*PARA-1:0] bound_q;
    logic [2:0]        fetch_k;
    logic [LW-1:0]     op1_q, op2_q, op3_q, op4_q, scal_q;
    logic [WD_W-1:0]   wd_q;
    logic [BEAT_W-1:0] beat_q;
    logic              err_q;
    logic              last_beat, wd_expire;
    logic [ADDR_W-1:0] tile_off;

    assign tile_inc  = tile_q + NT_W'(1);
    assign last_beat = (beat_q == BEAT_W'(TILE - 1));
    // Abort when this WAIT cycle brings the completed-cycle count to TIMEOUT-1.
    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 2));
    assign tile_off  = ADDR_W'({tile_q, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = (cmd_ntiles == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (fetch_k == 3'd4) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (s6_finished)    state_d = S_DRAIN;
                else if (wd_expire) state_d = S_DONE;
            end
            S_DRAIN: if (res_ready && last_beat) state_d = (tile_inc == ntiles_q) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result channel: a beat transfers on a cycle where res_valid and res_ready are both high;
    // while res_valid is high and res_ready is low, res_data and res_last stay unchanged.
    always_comb begin
        cmd_ready = 1'b0;
        rd_en     = 1'b0;
        s6_start  = 1'b0;
        res_valid = 1'b0;
        job_done  = 1'b0;
        job_err   = 1'b0;
        case (state_q)
            S_IDLE:  cmd_ready = 1'b1;
            S_FETCH: rd_en = (fetch_k != 3'd4);
            S_ISSUE: s6_start = 1'b1;
            S_DRAIN: res_valid = 1'b1;
            S_DONE: begin
                job_done = 1'b1;
                job_err  = err_q;
            end
            default: ;
        endcase
    end

    assign rd_addr   = rd_en ? (base_q + tile_off + ADDR_W'(fetch_k)) : '0;
    assign res_data  = res_valid ? s6_acc[int'(beat_q) * LW +: LW] : '0;
    assign res_last  = res_valid && last_beat;
    assign res_scal  = scal_q;
    assign s6_op1    = op1_q;
    assign s6_op2    = op2_q;
    assign s6_op3    = op3_q;
    assign s6_op4    = op4_q;
    assign s6_stage  = stage_q;
    assign s6_bound  = bound_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            ntiles_q <= '0;
            tile_q   <= '0;
            stage_q  <= '0;
            bound_q  <= '0;
            fetch_k  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op3_q    <= '0;
            op4_q    <= '0;
            scal_q   <= '0;
            wd_q     <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base_q   <= cmd_base;
                        ntiles_q <= cmd_ntiles;
                        stage_q  <= cmd_stage;
                        bound_q  <= cmd_bound;
                        tile_q   <= '0;
                        fetch_k  <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    fetch_k <= (fetch_k == 3'd4) ? 3'd0 : fetch_k + 3'd1;
                    // Read data lags the request by one cycle, so slot k lands in op(k).
                    case (fetch_k)
                        3'd1:    op1_q <= rd_data;
                        3'd2:    op2_q <= rd_data;
                        3'd3:    op3_q <= rd_data;
                        3'd4:    op4_q <= rd_data;
                        default: ;
                    endcase
                end
                S_ISSUE: wd_q <= '0;
                S_WAIT: begin
                    if (s6_finished) begin
                        scal_q <= s6_scal;
                        beat_q <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                        if (wd_expire) err_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            tile_q <= tile_inc;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage6_tile_feeder.sv
// Directed bench for stage6_tile_feeder: a read-port model and a stage6 model answer the feeder
// while scenario tasks check addresses, timing, result beats and job status.
`timescale 1ns/1ps
module tb_stage6_tile_feeder;
    localparam int WIDTH    = 16;
    localparam int PARALLEL = 3;
    localparam int PARA     = 8;
    localparam int TILE     = 128;
    localparam int ADDR_W   = 16;
    localparam int NT_W     = 8;
    localparam int TIMEOUT  = 1024;
    localparam int LW       = PARALLEL * WIDTH;
    localparam int ACC_W    = PARALLEL * TILE * WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [NT_W-1:0]   cmd_ntiles = '0;
    logic [4:0]        cmd_stage = '0;
    logic [8*PARA-1:0] cmd_bound = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [LW-1:0]     rd_data = '0;
    logic              s6_start;
    logic [LW-1:0]     s6_op1, s6_op2, s6_op3, s6_op4;
    logic [4:0]        s6_stage;
    logic [8*PARA-1:0] s6_bound;
    logic              s6_finished;
    logic [ACC_W-1:0]  s6_acc = '0;
    logic [LW-1:0]     s6_scal = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [LW-1:0]     res_data, res_scal;
    logic              res_last, job_done, job_err;
    logic [2:0]        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    stage6_tile_feeder #(
        .WIDTH(WIDTH), .PARALLEL(PARALLEL), .PARA(PARA), .TILE(TILE),
        .ADDR_W(ADDR_W), .NT_W(NT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
        .cmd_ntiles(cmd_ntiles), .cmd_stage(cmd_stage), .cmd_bound(cmd_bound),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .s6_start(s6_start), .s6_op1(s6_op1), .s6_op2(s6_op2), .s6_op3(s6_op3), .s6_op4(s6_op4),
        .s6_stage(s6_stage), .s6_bound(s6_bound), .s6_finished(s6_finished),
        .s6_acc(s6_acc), .s6_scal(s6_scal),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_scal(res_scal),
        .res_last(res_last), .job_done(job_done), .job_err(job_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_watchdog: got no finish expected finish within budget");
        $fatal(1);
    end

    // ---------------- device models ----------------
    function automatic logic [LW-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 16'h3C00, a ^ 16'h5A00, a};
    endfunction

    function automatic logic [WIDTH-1:0] elem(input int n, input int l, input int k);
        return 16'(((n & 15) << 12) | ((l & 3) << 10) | (k & 1023));
    endfunction

    function automatic logic [LW-1:0] acc_word(input int n, input int k);
        return {elem(n, 2, k), elem(n, 1, k), elem(n, 0, k)};
    endfunction

    function automatic logic [LW-1:0] scal_word(input int n);
        return {16'(16'hC200 + n), 16'(16'hC100 + n), 16'(16'hC000 + n)};
    endfunction

    always @(posedge clk) rd_data <= rd_en ? mem_word(rd_addr) : '0;

    // stage6 model: finished pulses fin_delay cycles after the start cycle (0 = never).
    int   fin_delay = 3;
    bit   spur_en = 1'b0;
    int   st_count = 0;
    int   cur_n = 0;
    int   cd = 0;
    bit   armed = 1'b0;
    logic fin_r = 1'b0;
    assign s6_finished = fin_r | (spur_en & s6_start);

    always @(posedge clk) begin
        fin_r <= 1'b0;
        if (!rst) begin
            armed <= 1'b0;
        end else if (s6_start) begin
            cur_n    <= st_count;
            st_count <= st_count + 1;
            armed    <= (fin_delay >= 2);
            cd       <= fin_delay - 2;
        end else if (armed) begin
            if (cd == 0) begin
                fin_r <= 1'b1;
                armed <= 1'b0;
                for (int k = 0; k < TILE; k++)
                    for (int l = 0; l < PARALLEL; l++)
                        s6_acc[(k*PARALLEL + l)*WIDTH +: WIDTH] <= elem(cur_n, l, k);
                s6_scal <= scal_word(cur_n);
            end else begin
                cd <= cd - 1;
            end
        end
    end

    // ---------------- scoreboard / observation ----------------
    logic [LW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [LW-1:0]     beat_log[$];
    bit                last_log[$];
    logic [LW-1:0]     scal_log[$];
    logic [4*LW-1:0]   op_log[$];
    int                start_log[$];
    logic [4:0]        stage_seen;
    logic [8*PARA-1:0] bound_seen;
    bit done_seen, done_err;
    int done_cyc, first_valid_cyc, last_beat_cyc, valid_cnt, ready_hi_cnt, hold_err;

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [ADDR_W-1:0] base, input logic [NT_W-1:0] nt,
                            input logic [4:0] stg, input logic [8*PARA-1:0] bnd, output int acc_cyc);
        @(negedge clk);
        cmd_base   = base;
        cmd_ntiles = nt;
        cmd_stage  = stg;
        cmd_bound  = bnd;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        acc_cyc = cmd_ready ? cyc : -1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int budget, input bit bp);
        bit            pend;
        logic [LW-1:0] pend_data;
        bit            pend_last;
        addr_log.delete(); beat_log.delete(); last_log.delete();
        scal_log.delete(); op_log.delete(); start_log.delete();
        done_seen = 0; done_err = 0; done_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
        valid_cnt = 0; ready_hi_cnt = 0; hold_err = 0; pend = 0;
        pend_data = '0; pend_last = 0;
        res_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rd_en) addr_log.push_back(rd_addr);
            if (s6_start) begin
                start_log.push_back(cyc);
                op_log.push_back({s6_op4, s6_op3, s6_op2, s6_op1});
                stage_seen = s6_stage;
                bound_seen = s6_bound;
            end
            if (cmd_ready) ready_hi_cnt++;
            if (pend && (!res_valid || res_data !== pend_data || res_last !== pend_last)) hold_err++;
            pend = 0;
            if (res_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (res_ready) begin
                    beat_log.push_back(res_data);
                    last_log.push_back(res_last);
                    if (res_last) scal_log.push_back(res_scal);
                    last_beat_cyc = cyc;
                end else begin
                    pend = 1; pend_data = res_data; pend_last = res_last;
                end
            end
            if (job_done) begin
                done_seen = 1; done_err = job_err; done_cyc = cyc;
                break;
            end
            @(negedge clk);
            if (bp) res_ready = ~res_ready;
        end
        res_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        tests_run++; if ({rd_en, s6_start, res_valid, job_done, job_err} !== 5'b0) begin tests_failed++; $display("FAIL rst_strobes: got %b expected 00000", {rd_en, s6_start, res_valid, job_done, job_err}); end
        tests_run++; if ({s6_op1, s6_op4, res_scal} !== '0) begin tests_failed++; $display("FAIL rst_regs: got %h expected 0", {s6_op1, s6_op4, res_scal}); end
        tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_single_tile();
        int acc_cyc, n0;
        logic [LW-1:0] exp_d, op_a, op_b;
        logic [ADDR_W-1:0] exp_addr[4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        fin_delay = 3; spur_en = 0;
        n0 = st_count;
        exp_q.delete();
        for (int k = 0; k < TILE; k++) exp_q.push_back(acc_word(n0, k));
        send_cmd(16'h0010, 8'd1, 5'h0A, 64'h0807_0605_0403_0201, acc_cyc);
        run_job(400, 1'b0);
        tests_run++; if (done_seen !== 1'b1) begin tests_failed++; $display("FAIL single_done: got %b expected 1", done_seen); end
        tests_run++; if (done_err !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", done_err); end
        tests_run++; if (addr_log.size() != 4) begin tests_failed++; $display("FAIL single_nreads: got %0d expected 4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            tests_run++; if (addr_log[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL single_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
        tests_run++;
        if (start_log.size() != 1) begin tests_failed++; $display("FAIL single_nstart: got %0d expected 1", start_log.size()); end
        else begin
            tests_run++; if (start_log[0] != acc_cyc + 6) begin tests_failed++; $display("FAIL single_start_lat: got %0d expected %0d", start_log[0] - acc_cyc, 6); end
            tests_run++; if (first_valid_cyc != start_log[0] + 4) begin tests_failed++; $display("FAIL single_drain_lat: got %0d expected %0d", first_valid_cyc - start_log[0], 4); end
            op_a = op_log[0][LW-1:0];
            op_b = op_log[0][4*LW-1 -: LW];
            tests_run++; if (op_a !== 48'h3C10_5A10_0010) begin tests_failed++; $display("FAIL single_op1: got %h expected 3c105a100010", op_a); end
            tests_run++; if (op_b !== 48'h3C13_5A13_0013) begin tests_failed++; $display("FAIL single_op4: got %h expected 3c135a130013", op_b); end
            tests_run++; if ({stage_seen, bound_seen} !== {5'h0A, 64'h0807_0605_0403_0201}) begin tests_failed++; $display("FAIL single_stage_bound: got %h_%h expected 0a_0807060504030201", stage_seen, bound_seen); end
        end
        tests_run++; if (beat_log.size() != TILE) begin tests_failed++; $display("FAIL single_nbeats: got %0d expected %0d", beat_log.size(), TILE); end
        for (int i = 0; i < beat_log.size() && exp_q.size() > 0; i++) begin
            exp_d = exp_q.pop_front();
            tests_run++; if (beat_log[i] !== exp_d) begin tests_failed++; $display("FAIL single_beat[%0d]: got %h expected %h", i, beat_log[i], exp_d); end
            tests_run++; if (last_log[i] !== (i == TILE-1)) begin tests_failed++; $display("FAIL single_last[%0d]: got %b expected %b", i, last_log[i], i == TILE-1); end
        end
        tests_run++; if (scal_log.size() != 1 || scal_log[0] !== scal_word(n0)) begin tests_failed++; $display("FAIL single_scal: got %0d entries expected 1 of %h", scal_log.size(), scal_word(n0)); end
        tests_run++; if (done_cyc != last_beat_cyc + 1) begin tests_failed++; $display("FAIL single_done_lat: got %0d expected 1", done_cyc - last_beat_cyc); end
        tests_run++; if (ready_hi_cnt != 0) begin tests_failed++; $display("FAIL single_busy_ready: got %0d expected 0", ready_hi_cnt); end
        @(negedge clk);
        tests_run++; if ({job_done, cmd_ready} !== 2'b01) begin tests_failed++; $display("FAIL single_after_done: got %b expected 01", {job_done, cmd_ready}); end
    endtask

    task automatic test_zero_tiles();
        int acc_cyc;
        send_cmd(16'h0100, 8'd0, 5'h01, 64'h0, acc_cyc);
        run_job(20, 1'b0);
        tests_run++; if (done_seen !== 1'b1 || done_cyc != acc_cyc + 1) begin tests_failed++; $display("FAIL zero_done_lat: got %0d expected 1", done_cyc - acc_cyc); end
        tests_run++; if (done_err !== 1'b0) begin tests_failed++; $display("FAIL zero_err: got %b expected 0", done_err); end
        tests_run++; if (addr_log.size() != 0 || start_log.size() != 0) begin tests_failed++; $display("FAIL zero_activity: got %0d reads %0d starts expected 0 0", addr_log.size(), start_log.size()); end
    endtask

    task automatic test_wrap_three_tiles();
        int acc_cyc, n0;
        logic [LW-1:0] exp_d;
        logic [ADDR_W-1:0] exp_addr[12] = '{16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC, 16'hFFFD,
                                            16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        fin_delay = 5; spur_en = 1;
        n0 = st_count;
        exp_q.delete();
        for (int t = 0; t < 3; t++)
            for (int k = 0; k < TILE; k++) exp_q.push_back(acc_word(n0 + t, k));
        send_cmd(16'hFFF8, 8'd3, 5'h11, 64'hAAAA_5555_0F0F_F0F0, acc_cyc);
        run_job(1000, 1'b0);
        spur_en = 0;
        tests_run++; if (done_seen !== 1'b1 || done_err !== 1'b0) begin tests_failed++; $display("FAIL wrap_done: got %b%b expected 10", done_seen, done_err); end
        tests_run++; if (addr_log.size() != 12) begin tests_failed++; $display("FAIL wrap_nreads: got %0d expected 12", addr_log.size()); end
        for (int i = 0; i < 12 && i < addr_log.size(); i++) begin
            tests_run++; if (addr_log[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
        tests_run++;
        if (start_log.size() != 3) begin tests_failed++; $display("FAIL wrap_nstart: got %0d expected 3", start_log.size()); end
        else begin
            tests_run++; if (first_valid_cyc != start_log[0] + 6) begin tests_failed++; $display("FAIL wrap_issue_fin_ignored: got %0d expected 6", first_valid_cyc - start_log[0]); end
        end
        tests_run++; if (beat_log.size() != 3*TILE) begin tests_failed++; $display("FAIL wrap_nbeats: got %0d expected %0d", beat_log.size(), 3*TILE); end
        for (int i = 0; i < beat_log.size() && exp_q.size() > 0; i++) begin
            exp_d = exp_q.pop_front();
            tests_run++; if (beat_log[i] !== exp_d) begin tests_failed++; $display("FAIL wrap_beat[%0d]: got %h expected %h", i, beat_log[i], exp_d); end
            tests_run++; if (last_log[i] !== (i % TILE == TILE-1)) begin tests_failed++; $display("FAIL wrap_last[%0d]: got %b expected %b", i, last_log[i], i % TILE == TILE-1); end
        end
        tests_run++;
        if (scal_log.size() != 3) begin tests_failed++; $display("FAIL wrap_nscal: got %0d expected 3", scal_log.size()); end
        else begin
            for (int t = 0; t < 3; t++) begin
                tests_run++; if (scal_log[t] !== scal_word(n0 + t)) begin tests_failed++; $display("FAIL wrap_scal[%0d]: got %h expected %h", t, scal_log[t], scal_word(n0 + t)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc_cyc, n0;
        logic [LW-1:0] exp_d;
        fin_delay = 3;
        n0 = st_count;
        exp_q.delete();
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < TILE; k++) exp_q.push_back(acc_word(n0 + t, k));
        send_cmd(16'h0200, 8'd2, 5'h03, 64'h1, acc_cyc);
        run_job(1200, 1'b1);
        tests_run++; if (done_seen !== 1'b1) begin tests_failed++; $display("FAIL bp_done: got %b expected 1", done_seen); end
        tests_run++; if (beat_log.size() != 2*TILE) begin tests_failed++; $display("FAIL bp_nbeats: got %0d expected %0d", beat_log.size(), 2*TILE); end
        tests_run++; if (hold_err != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d changes expected 0", hold_err); end
        tests_run++; if (valid_cnt <= 2*TILE) begin tests_failed++; $display("FAIL bp_stalls: got %0d valid cycles expected more than %0d", valid_cnt, 2*TILE); end
        for (int i = 0; i < beat_log.size() && exp_q.size() > 0; i++) begin
            exp_d = exp_q.pop_front();
            tests_run++; if (beat_log[i] !== exp_d) begin tests_failed++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, beat_log[i], exp_d); end
            tests_run++; if (last_log[i] !== (i % TILE == TILE-1)) begin tests_failed++; $display("FAIL bp_last[%0d]: got %b expected %b", i, last_log[i], i % TILE == TILE-1); end
        end
    endtask

    task automatic test_timeout();
        int acc_cyc;
        fin_delay = 0;
        send_cmd(16'h0040, 8'd2, 5'h07, 64'h2, acc_cyc);
        run_job(TIMEOUT + 200, 1'b0);
        fin_delay = 3;
        tests_run++; if (done_seen !== 1'b1 || done_err !== 1'b1) begin tests_failed++; $display("FAIL to_done_err: got %b%b expected 11", done_seen, done_err); end
        tests_run++;
        if (start_log.size() != 1) begin tests_failed++; $display("FAIL to_nstart: got %0d expected 1", start_log.size()); end
        else begin
            tests_run++; if (done_cyc != start_log[0] + TIMEOUT) begin tests_failed++; $display("FAIL to_latency: got %0d expected %0d", done_cyc - start_log[0], TIMEOUT); end
        end
        tests_run++; if (valid_cnt != 0) begin tests_failed++; $display("FAIL to_no_result: got %0d expected 0", valid_cnt); end
        @(negedge clk);
        tests_run++; if ({job_done, job_err} !== 2'b00) begin tests_failed++; $display("FAIL to_pulse_width: got %b expected 00", {job_done, job_err}); end
    endtask

    task automatic test_reset_mid_drain();
        int acc_cyc, wait_n, done_cnt;
        fin_delay = 3;
        send_cmd(16'h0080, 8'd1, 5'h02, 64'h3, acc_cyc);
        wait_n = 0;
        while (!res_valid && wait_n < 40) begin @(negedge clk); wait_n++; end
        tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_reach_drain: got %b expected 1", res_valid); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if ({res_valid, cmd_ready, rd_en} !== 3'b010) begin tests_failed++; $display("FAIL rstmid_async: got %b expected 010", {res_valid, cmd_ready, rd_en}); end
        @(posedge clk); #1;
        tests_run++; if ({res_valid, cmd_ready, job_done} !== 3'b010) begin tests_failed++; $display("FAIL rstmid_edge: got %b expected 010", {res_valid, cmd_ready, job_done}); end
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (20) begin @(negedge clk); if (job_done) done_cnt++; end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt); end
        send_cmd(16'h0020, 8'd1, 5'h04, 64'h4, acc_cyc);
        run_job(400, 1'b0);
        tests_run++; if (done_seen !== 1'b1 || beat_log.size() != TILE) begin tests_failed++; $display("FAIL rstmid_recover: got done=%b beats=%0d expected 1 %0d", done_seen, beat_log.size(), TILE); end
        tests_run++; if (op_log.size() != 1 || op_log[0][LW-1:0] !== 48'h3C20_5A20_0020) begin tests_failed++; $display("FAIL rstmid_recover_op1: got %0d starts expected op1 3c205a200020", op_log.size()); end
    endtask

    // ---------------- sequence / final report ----------------
    initial begin
        test_reset();
        test_single_tile();
        test_zero_tiles();
        test_wrap_three_tiles();
        test_backpressure();
        test_timeout();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
